pwm_generator: RTL and testbench

- Downstream consumer of the free-running Counter: compares the Counter's `count` against a programmed duty value and drives a glitch-free PWM output.
- Duty updates arrive over a valid/ready handshake into a pending register. They take effect only at a period boundary, which is a Counter wrap.
- Emits a one-cycle period pulse per wrap, used for downstream sequencing.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/wrap_detect.sv | 28 ++
 rtl/pwm_generator.sv | 80 ++++++++
 tb/tb_pwm_generator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator and other Counter consumers.
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_DISABLED = 2'd0,
    PWM_ARMED    = 2'd1,
    PWM_RUNNING  = 2'd2
  } pwm_state_e;

  // Clamp a duty request to one full period (2^width clocks); valid for width <= 30.
  function automatic int unsigned sat_duty(input int unsigned d, input int unsigned width);
    int unsigned lim;
    lim = 32'd1 << width;
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/wrap_detect.sv
// Flags a period boundary: the incoming count went down relative to last cycle.
module wrap_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count,
  output logic             wrap_evt
);

  logic [WIDTH-1:0] prev_count;
  logic             prev_valid;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_count <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_count <= count;
      prev_valid <= 1'b1;
    end
  end

  // A Counter reset also looks like a wrap; prev_valid masks the first cycle after our reset.
  assign wrap_evt = prev_valid && (count < prev_count);

endmodule

// File: rtl/pwm_generator.sv
// Glitch-free PWM driven from a free-running Counter; duty changes land on period boundaries.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic [WIDTH:0]   duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_pulse,
  output logic [WIDTH:0]   active_duty
);

  pwm_state_e     state, state_next;
  logic           wrap_evt;
  logic           pending_full;
  logic [WIDTH:0] pending_duty;
  logic [WIDTH:0] duty_sat;
  logic [WIDTH:0] active_duty_next;
  logic           accept;
  logic           transfer;

  wrap_detect #(.WIDTH(WIDTH)) u_wrap_detect (
    .clock    (clock),
    .reset_n  (reset_n),
    .count    (count),
    .wrap_evt (wrap_evt)
  );

  assign duty_sat   = (WIDTH+1)'(sat_duty(32'(duty), WIDTH));
  assign duty_ready = !pending_full;
  assign accept     = duty_valid && duty_ready;

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      PWM_DISABLED: if (enable) state_next = PWM_ARMED;
      PWM_ARMED: begin
        if (!enable)       state_next = PWM_DISABLED;
        else if (wrap_evt) state_next = PWM_RUNNING;
      end
      PWM_RUNNING:  if (!enable) state_next = PWM_DISABLED;
      default:      state_next = PWM_DISABLED;
    endcase
  end

  // accept needs an empty pending slot and transfer a full one, so they never coincide;
  // a duty accepted on a wrap cycle therefore waits for the following wrap.
  assign transfer         = wrap_evt && pending_full && (state_next == PWM_RUNNING);
  assign active_duty_next = transfer ? pending_duty : active_duty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PWM_DISABLED;
      pending_full <= 1'b0;
      pending_duty <= '0;
      active_duty  <= '0;
      pwm_out      <= 1'b0;
      period_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      active_duty <= active_duty_next;
      if (transfer) begin
        pending_full <= 1'b0;
      end else if (accept) begin
        pending_full <= 1'b1;
        pending_duty <= duty_sat;
      end
      pwm_out      <= (state_next == PWM_RUNNING) && ({1'b0, count} < active_duty_next);
      period_pulse <= wrap_evt && (state_next != PWM_DISABLED);
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed plus randomized bench for pwm_generator (WIDTH=4) against a behavioural period model.
module tb_pwm_generator;

  localparam int W = 4;
  localparam int P = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] count = '0;
  logic         enable = 1'b0;
  logic [W:0]   duty = '0;
  logic         duty_valid = 1'b0;
  logic         duty_ready;
  logic         pwm_out;
  logic         period_pulse;
  logic [W:0]   active_duty;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: mode 0=off, 1=waiting for a boundary, 2=generating.
  int m_mode;
  int m_prev;
  bit m_prev_valid;
  int m_act;
  int m_pend[$];
  bit e_pwm;
  bit e_pulse;

  int cnt;
  int hi_cnt;
  int pulse_cnt;

  pwm_generator #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .count        (count),
    .enable       (enable),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_pulse (period_pulse),
    .active_duty  (active_duty)
  );

  always #5 clock = ~clock;

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_prev = 0;
    m_prev_valid = 1'b0;
    m_act = 0;
    m_pend.delete();
  endtask

  // One clock of the model from the inputs currently driven.
  task automatic model_eval();
    bit wrap;
    int pend_was;
    int d;
    wrap = m_prev_valid && (cnt < m_prev);
    m_prev = cnt;
    m_prev_valid = 1'b1;
    if (!enable)                 m_mode = 0;
    else if (m_mode == 0)        m_mode = 1;
    else if (m_mode == 1 && wrap) m_mode = 2;
    pend_was = m_pend.size();
    if (wrap && m_mode == 2 && pend_was != 0) m_act = m_pend.pop_front();
    if (duty_valid && pend_was == 0) begin
      d = int'(duty);
      m_pend.push_back((d > P) ? P : d);
    end
    e_pwm = (m_mode == 2) && (cnt < m_act);
    e_pulse = wrap && (m_mode != 0);
  endtask

  task automatic step();
    check("duty_ready", 32'(duty_ready), 32'(m_pend.size() == 0));
    model_eval();
    @(posedge clock);
    #1;
    check("pwm_out", 32'(pwm_out), 32'(e_pwm));
    check("period_pulse", 32'(period_pulse), 32'(e_pulse));
    check("active_duty", 32'(active_duty), 32'(m_act));
    hi_cnt += int'(pwm_out);
    pulse_cnt += int'(period_pulse);
    cnt = (cnt + 1) % P;
    count = W'(cnt);
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 2 * P && cnt != c; i++) step();
  endtask

  task automatic offer(input int d);
    duty = (W+1)'(d);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    cnt = 0;
    hi_cnt = 0;
    pulse_cnt = 0;

    repeat (2) @(posedge clock);
    #1;
    check("reset pwm_out", 32'(pwm_out), 0);
    check("reset period_pulse", 32'(period_pulse), 0);
    check("reset active_duty", 32'(active_duty), 0);
    check("reset duty_ready", 32'(duty_ready), 1);
    reset_n = 1'b1;

    // duty=4 from DISABLED: silent until the first wrap, then 4/16 high.
    enable = 1'b1;
    hi_cnt = 0;
    offer(4);
    run_to(0);
    check("pre-wrap highs", 32'(hi_cnt), 0);
    hi_cnt = 0;
    pulse_cnt = 0;
    repeat (2 * P) step();
    check("duty4 highs over 2 periods", 32'(hi_cnt), 8);
    check("duty4 pulses over 2 periods", 32'(pulse_cnt), 2);

    // Extremes.
    offer(0);
    run_to(0);
    hi_cnt = 0;
    repeat (3 * P) step();
    check("duty0 highs", 32'(hi_cnt), 0);
    offer(16);
    run_to(0);
    hi_cnt = 0;
    repeat (3 * P) step();
    check("duty16 highs", 32'(hi_cnt), 48);
    offer(31);
    run_to(0);
    step();
    check("duty31 saturated", 32'(active_duty), 16);

    // Back-pressure: 8 accepted, 12 held until the slot frees after the wrap.
    run_to(3);
    offer(8);
    duty = 5'd12;
    duty_valid = 1'b1;
    run_to(0);
    hi_cnt = 0;
    step();
    check("backpressure active 8", 32'(active_duty), 8);
    step();
    duty_valid = 1'b0;
    repeat (P - 2) step();
    check("backpressure highs 8", 32'(hi_cnt), 8);
    hi_cnt = 0;
    repeat (P) step();
    check("backpressure highs 12", 32'(hi_cnt), 12);

    // Accept on the exact wrap cycle: applies one wrap later.
    run_to(0);
    hi_cnt = 0;
    offer(6);
    check("same-cycle old duty", 32'(active_duty), 12);
    repeat (P - 1) step();
    check("same-cycle highs old", 32'(hi_cnt), 12);
    hi_cnt = 0;
    repeat (P) step();
    check("same-cycle highs new", 32'(hi_cnt), 6);

    // enable drop mid-high phase, re-enable mid-period.
    offer(10);
    run_to(0);
    step();
    run_to(2);
    enable = 1'b0;
    step();
    check("drop pwm_out", 32'(pwm_out), 0);
    run_to(5);
    enable = 1'b1;
    hi_cnt = 0;
    step();
    run_to(0);
    check("rearmed highs before wrap", 32'(hi_cnt), 0);
    hi_cnt = 0;
    repeat (P) step();
    check("rearmed highs 10", 32'(hi_cnt), 10);

    // Randomized traffic, including occasional Counter restarts.
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      duty = (W+1)'($urandom_range(0, 31));
      duty_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) begin
        cnt = $urandom_range(0, P - 1);
        count = W'(cnt);
      end
      step();
    end

    // Asynchronous reset in the middle of a high phase.
    enable = 1'b1;
    duty_valid = 1'b0;
    offer(10);
    repeat (3 * P) step();
    run_to(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async pwm_out", 32'(pwm_out), 0);
    check("async period_pulse", 32'(period_pulse), 0);
    check("async active_duty", 32'(active_duty), 0);
    check("async duty_ready", 32'(duty_ready), 1);
    #2;
    reset_n = 1'b1;
    model_reset();
    step();
    check("post-reset no pulse", 32'(period_pulse), 0);
    offer(7);
    repeat (3 * P) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
